// File: rtl/mode_cmd_encoder_if.sv
// mode_cmd_encoder_if
//   Bundles the command handshake and the transmitter byte handshake of
//   mode_cmd_encoder.
//   Handshake rule: a transfer happens on a rising clk edge where both
//   its valid and its ready are high. The producer holds valid and its
//   payload stable until that edge. The consumer may hold ready low for
//   any number of cycles.
//   Signals:
//     valid     command request (command side)
//     cmd       command code: 00 DATA, 01 SET_RATE, 10 CLEAN, 11 reserved
//     rate_code rate code for SET_RATE: 00 '1', 01 '5', 11 'A', 10 illegal
//     data      payload byte for DATA
//     ready     encoder is idle and can accept a command
//     tx_data   byte offered to the transmitter (00 while tx_valid low)
//     tx_valid  tx_data holds a byte awaiting transfer
//     tx_ready  transmitter takes the byte
//     done      one-cycle pulse after the last byte of a command
//     err       one-cycle pulse after a rejected command
//     rate      rate code last sent to the far end
//   master: the command source and transmitter side (the bench).
//   slave:  the encoder.
interface mode_cmd_encoder_if;
   logic       valid;
   logic [1:0] cmd;
   logic [1:0] rate_code;
   logic [7:0] data;
   logic       ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       done;
   logic       err;
   logic [1:0] rate;

   modport master (
      output valid, cmd, rate_code, data, tx_ready,
      input  ready, tx_data, tx_valid, done, err, rate
   );

   modport slave (
      input  valid, cmd, rate_code, data, tx_ready,
      output ready, tx_data, tx_valid, done, err, rate
   );
endinterface

// File: rtl/mode_cmd_encoder.sv
// mode_cmd_encoder
//   Turns mode commands into byte sequences for a serial transmitter:
//     DATA     -> {data}
//     SET_RATE -> {'M', rate char, 'F'}
//     CLEAN    -> {'C'}
//   Consecutive bytes are separated by GAP_CYCLES idle cycles (1..15).
//   The same gap also follows the end of every command.
//   Illegal commands are rejected with an err pulse. A rejected command
//   sends no byte.
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous active-high reset
//     bus        mode_cmd_encoder_if.slave (command and transmitter handshakes)
//     dbg_state  current FSM state (00 IDLE, 01 SEND, 10 GAP, 11 DONE)
module mode_cmd_encoder #(
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   mode_cmd_encoder_if.slave bus,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] CMD_DATA  = 2'b00;
   localparam logic [1:0] CMD_RATE  = 2'b01;
   localparam logic [1:0] CMD_CLEAN = 2'b10;
   localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

   state_t     state;
   logic [1:0] cmd_q;
   logic [1:0] rate_q;
   logic [7:0] data_q;
   logic [1:0] idx;
   logic [3:0] gap_cnt;
   logic       tail;     // set while the GAP that follows DONE is running
   logic       accept;

   assign accept    = bus.valid && bus.ready;
   assign dbg_state = state;

   function automatic logic [7:0] rate_char(input logic [1:0] r);
      case (r)
         2'b00:   return 8'h31;  // '1'
         2'b01:   return 8'h35;  // '5'
         default: return 8'h41;  // 'A' (10 never gets this far)
      endcase
   endfunction

   function automatic logic [7:0] cmd_byte(input logic [1:0] c, input logic [1:0] r,
                                           input logic [7:0] d, input logic [1:0] i);
      case (c)
         CMD_RATE: begin
            case (i)
               2'd0:    return 8'h4D;
               2'd1:    return rate_char(r);
               default: return 8'h46;
            endcase
         end
         CMD_CLEAN: return 8'h43;
         default:   return d;
      endcase
   endfunction

   // Index of the final byte: 2 for SET_RATE, 0 for the one-byte commands.
   function automatic logic [1:0] last_idx(input logic [1:0] c);
      return (c == CMD_RATE) ? 2'd2 : 2'd0;
   endfunction

   // A DATA payload must not be confused with a framing character
   // ('M', 'F', 'C' in either case) or with the idle value 00.
   function automatic logic is_reject(input logic [1:0] c, input logic [1:0] r,
                                      input logic [7:0] d);
      logic bad_data;
      bad_data = (d == 8'h00) || (d == 8'h4D) || (d == 8'h6D) || (d == 8'h46) ||
                 (d == 8'h66) || (d == 8'h43) || (d == 8'h63);
      return (c == 2'b11) || ((c == CMD_RATE) && (r == 2'b10)) ||
             ((c == CMD_DATA) && bad_data);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         bus.ready    <= 1'b0;
         bus.tx_valid <= 1'b0;
         bus.tx_data  <= 8'h00;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
         bus.rate     <= 2'b00;
         cmd_q        <= 2'b00;
         rate_q       <= 2'b00;
         data_q       <= 8'h00;
         idx          <= 2'd0;
         gap_cnt      <= 4'd0;
         tail         <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: begin
               bus.ready <= 1'b1;
               if (accept) begin
                  // ready drops for one cycle even on a reject, so err and a
                  // new acceptance never coincide
                  bus.ready <= 1'b0;
                  if (is_reject(bus.cmd, bus.rate_code, bus.data)) begin
                     bus.err <= 1'b1;
                  end else begin
                     cmd_q        <= bus.cmd;
                     rate_q       <= bus.rate_code;
                     data_q       <= bus.data;
                     idx          <= 2'd0;
                     tail         <= 1'b0;
                     state        <= SEND;
                     bus.tx_valid <= 1'b1;
                     bus.tx_data  <= cmd_byte(bus.cmd, bus.rate_code, bus.data, 2'd0);
                  end
               end
            end
            SEND: begin
               if (bus.tx_ready) begin
                  bus.tx_valid <= 1'b0;
                  bus.tx_data  <= 8'h00;
                  gap_cnt      <= 4'd0;
                  if (idx == last_idx(cmd_q)) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                     if (cmd_q == CMD_RATE) begin
                        bus.rate <= rate_q;
                     end else if (cmd_q == CMD_CLEAN) begin
                        bus.rate <= 2'b00;
                     end
                  end else begin
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (tail) begin
                     state     <= IDLE;
                     bus.ready <= 1'b1;
                  end else begin
                     state        <= SEND;
                     idx          <= idx + 2'd1;
                     bus.tx_valid <= 1'b1;
                     bus.tx_data  <= cmd_byte(cmd_q, rate_q, data_q, idx + 2'd1);
                  end
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            DONE: begin
               state   <= GAP;
               idx     <= 2'd0;
               gap_cnt <= 4'd0;
               tail    <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mode_cmd_encoder.sv
// tb_mode_cmd_encoder
//   Directed bench for mode_cmd_encoder with GAP_CYCLES = 2.
//   Inputs are driven 1 time unit after the rising edge.
//   Outputs are sampled at the same point, after the registers have settled.
module tb_mode_cmd_encoder;
   localparam int GAP = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] dbg_state;

   mode_cmd_encoder_if bus ();

   mode_cmd_encoder #(.GAP_CYCLES(GAP)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int         vec_count   = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int         xfer_cnt = 0;
   int         done_cnt = 0;
   int         err_cnt  = 0;

   // byte / pulse monitor
   always @(posedge clk) begin
      if (bus.tx_valid && bus.tx_ready) begin
         obs_q.push_back(bus.tx_data);
         xfer_cnt <= xfer_cnt + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.err) err_cnt <= err_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: returns 1 and queues bytes for a legal command
   function automatic bit model_push(input logic [1:0] c, input logic [1:0] r,
                                     input logic [7:0] d);
      if (c == 2'b11) return 1'b0;
      if (c == 2'b01 && r == 2'b10) return 1'b0;
      if (c == 2'b00 && (d == 8'h00 || d == 8'h4D || d == 8'h6D || d == 8'h46 ||
                         d == 8'h66 || d == 8'h43 || d == 8'h63)) return 1'b0;
      case (c)
         2'b00: exp_q.push_back(d);
         2'b01: begin
            exp_q.push_back(8'h4D);
            exp_q.push_back(r == 2'b00 ? 8'h31 : (r == 2'b01 ? 8'h35 : 8'h41));
            exp_q.push_back(8'h46);
         end
         default: exp_q.push_back(8'h43);
      endcase
      return 1'b1;
   endfunction

   task automatic run_to_ready(input string name);
      int n;
      n = 0;
      while (bus.ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      vec_count++;
      if (bus.ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_ready_timeout: ready=%b after %0d cycles, required 1", name, bus.ready, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.valid = 1'b0; bus.cmd = 2'b00; bus.rate_code = 2'b00; bus.data = 8'h00;
      bus.tx_ready = 1'b0;
      repeat (2) tick();
      vec_count++;
      if ({bus.tx_valid, bus.tx_data, bus.done, bus.err, bus.rate, bus.ready, dbg_state} !==
          {1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00}) begin
         miscompares++;
         $display("FAIL reset_state: vld=%b data=%h done=%b err=%b rate=%b rdy=%b st=%b, required 0 00 0 0 00 0 00",
                  bus.tx_valid, bus.tx_data, bus.done, bus.err, bus.rate, bus.ready, dbg_state);
      end
      reset = 1'b0;
      tick();
      vec_count++;
      if ({bus.ready, bus.tx_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_release: rdy=%b vld=%b, required rdy=1 vld=0", bus.ready, bus.tx_valid);
      end
   endtask

   // SET_RATE '5' with the transmitter always ready: exact cycle trace
   task automatic test_set_rate();
      logic [7:0] tbl[11];
      logic [13:0] exp_v;
      int c;
      tbl = '{8'h4D, 8'h00, 8'h00, 8'h35, 8'h00, 8'h00, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00};
      bus.tx_ready = 1'b1;
      bus.valid = 1'b1; bus.cmd = 2'b01; bus.rate_code = 2'b01; bus.data = 8'h00;
      tick();
      // later field changes must not affect the command in progress
      bus.valid = 1'b0; bus.cmd = 2'b10; bus.rate_code = 2'b11; bus.data = 8'h77;
      for (int i = 0; i < 11; i++) begin
         c = i + 1;
         exp_v = {(tbl[i] != 8'h00), tbl[i], (c == 8), 1'b0, (c == 11), ((c >= 8) ? 2'b01 : 2'b00)};
         vec_count++;
         if ({bus.tx_valid, bus.tx_data, bus.done, bus.err, bus.ready, bus.rate} !== exp_v) begin
            miscompares++;
            $display("FAIL set_rate_c%0d: vld/data/done/err/rdy/rate=%b/%h/%b/%b/%b/%b, required %b/%h/%b/%b/%b/%b",
                     c, bus.tx_valid, bus.tx_data, bus.done, bus.err, bus.ready, bus.rate,
                     exp_v[13], exp_v[12:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1:0]);
         end
         if (i < 10) tick();
      end
   endtask

   // DATA 41 with the transmitter stalled for 5 cycles
   task automatic test_stall();
      int x0;
      bus.tx_ready = 1'b0;
      bus.valid = 1'b1; bus.cmd = 2'b00; bus.data = 8'h41;
      tick();
      bus.valid = 1'b0; bus.data = 8'h99;
      x0 = xfer_cnt;
      for (int i = 1; i <= 6; i++) begin
         vec_count++;
         if ({bus.tx_valid, bus.tx_data, bus.done, bus.ready} !== {1'b1, 8'h41, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold_c%0d: vld=%b data=%h done=%b rdy=%b, required 1 41 0 0",
                     i, bus.tx_valid, bus.tx_data, bus.done, bus.ready);
         end
         if (i == 6) bus.tx_ready = 1'b1;
         tick();
      end
      vec_count++;
      if ({bus.tx_valid, bus.tx_data, bus.done, bus.rate} !== {1'b0, 8'h00, 1'b1, 2'b01}) begin
         miscompares++;
         $display("FAIL stall_done: vld=%b data=%h done=%b rate=%b, required 0 00 1 01",
                  bus.tx_valid, bus.tx_data, bus.done, bus.rate);
      end
      vec_count++;
      if (xfer_cnt - x0 !== 1) begin
         miscompares++;
         $display("FAIL stall_xfers: got %0d transfers, required 1", xfer_cnt - x0);
      end
      // tx_ready stays high through the tail gap and must be ignored
      for (int j = 0; j < 3; j++) begin
         tick();
         vec_count++;
         if ({bus.ready, bus.tx_valid} !== {(j == 2), 1'b0}) begin
            miscompares++;
            $display("FAIL stall_tail_%0d: rdy=%b vld=%b, required %b 0", j, bus.ready, bus.tx_valid, (j == 2));
         end
      end
   endtask

   task automatic test_reject();
      logic [1:0] cm[5];
      logic [1:0] rc[5];
      logic [7:0] dt[5];
      int x0;
      cm = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
      rc = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
      dt = '{8'h6D, 8'h20, 8'h41, 8'h00, 8'h63};
      x0 = xfer_cnt;
      for (int k = 0; k < 5; k++) begin
         bus.valid = 1'b1; bus.cmd = cm[k]; bus.rate_code = rc[k]; bus.data = dt[k];
         tick();
         bus.valid = 1'b0;
         vec_count++;
         if ({bus.err, bus.done, bus.tx_valid, bus.ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reject%0d_pulse: err=%b done=%b vld=%b rdy=%b, required 1 0 0 0",
                     k, bus.err, bus.done, bus.tx_valid, bus.ready);
         end
         tick();
         vec_count++;
         if ({bus.err, bus.tx_valid, bus.ready, bus.rate} !== {1'b0, 1'b0, 1'b1, 2'b01}) begin
            miscompares++;
            $display("FAIL reject%0d_after: err=%b vld=%b rdy=%b rate=%b, required 0 0 1 01",
                     k, bus.err, bus.tx_valid, bus.ready, bus.rate);
         end
      end
      vec_count++;
      if (xfer_cnt !== x0) begin
         miscompares++;
         $display("FAIL reject_xfers: got %0d transfers, required 0", xfer_cnt - x0);
      end
   endtask

   // reset pulse during the gap after 'M' of a SET_RATE 'A'
   task automatic test_reset_mid();
      int x0;
      int d0;
      bus.tx_ready = 1'b1;
      bus.valid = 1'b1; bus.cmd = 2'b01; bus.rate_code = 2'b11;
      tick();
      bus.valid = 1'b0;
      vec_count++;
      if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h4D}) begin
         miscompares++;
         $display("FAIL midrst_first: vld=%b data=%h, required 1 4D", bus.tx_valid, bus.tx_data);
      end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      x0 = xfer_cnt;
      d0 = done_cnt;
      vec_count++;
      if ({bus.tx_valid, bus.tx_data, bus.done, bus.err, bus.rate, bus.ready, dbg_state} !==
          {1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00}) begin
         miscompares++;
         $display("FAIL midrst_state: vld=%b data=%h done=%b err=%b rate=%b rdy=%b st=%b, required 0 00 0 0 00 0 00",
                  bus.tx_valid, bus.tx_data, bus.done, bus.err, bus.rate, bus.ready, dbg_state);
      end
      tick();
      vec_count++;
      if (bus.ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_ready: rdy=%b, required 1", bus.ready);
      end
      repeat (8) tick();
      vec_count++;
      if ({(xfer_cnt - x0), (done_cnt - d0), bus.rate} !== {32'd0, 32'd0, 2'b00}) begin
         miscompares++;
         $display("FAIL midrst_quiet: xfers=%0d dones=%0d rate=%b, required 0 0 00",
                  xfer_cnt - x0, done_cnt - d0, bus.rate);
      end
   endtask

   task automatic test_clean();
      bit ok;
      obs_q.delete();
      exp_q.delete();
      bus.tx_ready = 1'b1;
      bus.valid = 1'b1; bus.cmd = 2'b01; bus.rate_code = 2'b11;
      ok = model_push(2'b01, 2'b11, 8'h00);
      tick();
      bus.valid = 1'b0;
      run_to_ready("clean_pre");
      vec_count++;
      if (bus.rate !== 2'b11) begin
         miscompares++;
         $display("FAIL clean_pre_rate: rate=%b, required 11", bus.rate);
      end
      bus.valid = 1'b1; bus.cmd = 2'b10;
      ok = model_push(2'b10, 2'b00, 8'h00);
      tick();
      bus.valid = 1'b0;
      vec_count++;
      if ({bus.tx_valid, bus.tx_data, bus.rate} !== {1'b1, 8'h43, 2'b11}) begin
         miscompares++;
         $display("FAIL clean_byte: vld=%b data=%h rate=%b, required 1 43 11", bus.tx_valid, bus.tx_data, bus.rate);
      end
      tick();
      vec_count++;
      if ({bus.done, bus.tx_valid, bus.rate} !== {1'b1, 1'b0, 2'b00}) begin
         miscompares++;
         $display("FAIL clean_done: done=%b vld=%b rate=%b, required 1 0 00", bus.done, bus.tx_valid, bus.rate);
      end
      run_to_ready("clean_post");
      vec_count++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL clean_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            vec_count++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL clean_byte%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   // valid held high while fields change every cycle
   task automatic test_back_to_back();
      logic [1:0] cm[6];
      logic [1:0] rc[6];
      logic [7:0] dt[6];
      int err0;
      int exp_err;
      int k;
      cm = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
      rc = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01};
      dt = '{8'h11, 8'h4D, 8'h4D, 8'h00, 8'hA5, 8'h66};
      obs_q.delete();
      exp_q.delete();
      err0 = err_cnt;
      exp_err = 0;
      bus.valid = 1'b1;
      for (int cyc = 0; cyc < 150; cyc++) begin
         k = cyc % 6;
         bus.cmd = cm[k]; bus.rate_code = rc[k]; bus.data = dt[k];
         if (bus.ready === 1'b1) begin
            if (!model_push(cm[k], rc[k], dt[k])) exp_err++;
         end
         bus.tx_ready = 1'($urandom_range(0, 1));
         tick();
      end
      bus.valid = 1'b0;
      bus.tx_ready = 1'b1;
      run_to_ready("b2b");
      vec_count++;
      if (err_cnt - err0 !== exp_err) begin
         miscompares++;
         $display("FAIL b2b_errs: got %0d err pulses, required %0d", err_cnt - err0, exp_err);
      end
      vec_count++;
      if (obs_q.size() != exp_q.size() || exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d bytes, required %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            vec_count++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL b2b_byte%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_set_rate();
      test_stall();
      test_reject();
      test_reset_mid();
      test_clean();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
